// File: rtl/sser_key_pkg.sv
// Shared types and constants for the SSER serial key sequencer: FSM states,
// the fixed unlock code sequence and the local bus drive patterns.
package sser_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        U_STB,
        U_GAP,
        R_STB,
        R_GAP,
        DONE
    } state_t;

    localparam int UNLOCK_MAX   = 4;
    localparam int UNLOCK_IDX_W = 2;
    localparam int STEP_W       = 6;

    localparam logic [3:0] UNLOCK_SEQ [UNLOCK_MAX] = '{4'h2, 4'h8, 4'hA, 4'h9};
    localparam logic [3:0] READ_CODE = 4'h0;

    typedef struct packed {
        logic       sser_n;
        logic       ba13;
        logic       ba12;
        logic [3:0] ba;
        logic       br_w;
    } bus_drv_t;

    localparam bus_drv_t BUS_IDLE = '{sser_n: 1'b1, ba13: 1'b1, ba12: 1'b0, ba: 4'h0, br_w: 1'b0};

    // Drive pattern for one strobed read inside the SSER window.
    function automatic bus_drv_t bus_strobe(input logic [3:0] code);
        return '{sser_n: 1'b0, ba13: 1'b0, ba12: 1'b1, ba: code, br_w: 1'b1};
    endfunction

    function automatic logic [3:0] unlock_code(input logic [STEP_W-1:0] idx);
        return UNLOCK_SEQ[idx[UNLOCK_IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/sser_bit_capture.sv
// MSB-first shift register that assembles the serial key word from SDRD.
// Cleared when a request is accepted, shifted once per read strobe.
module sser_bit_capture #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                sdrd,
    output logic [NUM_BITS-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (shift_en) begin
            // The cast drops the old MSB and keeps this legal for NUM_BITS=1.
            data <= NUM_BITS'({data, sdrd});
        end
    end

endmodule

// File: rtl/sser_key_sequencer.sv
// Bus-master sequencer: wins the local bus, issues the unlock strobes, then
// clocks NUM_BITS read strobes and returns the captured key word to the host.
module sser_key_sequencer
    import sser_key_pkg::*;
#(
    parameter int NUM_BITS    = 16,
    parameter int UNLOCK_LEN  = 4,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NUM_BITS-1:0] key_data,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                sser_n,
    output logic                ba13,
    output logic                ba12,
    output logic [3:0]          ba,
    output logic                br_w,
    input  logic                sdrd
);

    localparam int WAIT_W = $clog2(GNT_TIMEOUT + 1);

    state_t              state, state_nx;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
    logic [STEP_W-1:0]   step_cnt, step_cnt_nx;
    logic                err_nx;
    logic                cap_clear;
    logic                bus_req_nx;
    bus_drv_t            bus_q, bus_nx;
    logic [NUM_BITS-1:0] cap_data;

    sser_bit_capture #(
        .NUM_BITS (NUM_BITS)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .clear    (cap_clear),
        .shift_en (state == R_STB),
        .sdrd     (sdrd),
        .data     (cap_data)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        step_cnt_nx = step_cnt;
        err_nx      = 1'b0;
        cap_clear   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = REQ;
                    wait_cnt_nx = '0;
                    cap_clear   = 1'b1;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_nx    = U_STB;
                    step_cnt_nx = '0;
                end else if (wait_cnt == WAIT_W'(GNT_TIMEOUT)) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                end
            end
            U_STB: begin
                if (!bus_gnt) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    state_nx = U_GAP;
                end
            end
            U_GAP: begin
                if (!bus_gnt) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (step_cnt == STEP_W'(UNLOCK_LEN - 1)) begin
                    state_nx    = R_STB;
                    step_cnt_nx = '0;
                end else begin
                    state_nx    = U_STB;
                    step_cnt_nx = step_cnt + STEP_W'(1);
                end
            end
            R_STB: begin
                if (!bus_gnt) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    state_nx = R_GAP;
                end
            end
            R_GAP: begin
                if (!bus_gnt) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (step_cnt == STEP_W'(NUM_BITS - 1)) begin
                    state_nx = DONE;
                end else begin
                    state_nx    = R_STB;
                    step_cnt_nx = step_cnt + STEP_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus drive is derived from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        bus_req_nx = (state_nx inside {REQ, U_STB, U_GAP, R_STB, R_GAP});
        bus_nx     = bus_q;

        case (state_nx)
            U_STB:        bus_nx = bus_strobe(unlock_code(step_cnt_nx));
            R_STB:        bus_nx = bus_strobe(READ_CODE);
            U_GAP, R_GAP: bus_nx.sser_n = 1'b1;
            default:      bus_nx = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            bus_req  <= 1'b0;
            bus_q    <= BUS_IDLE;
            key_data <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            step_cnt <= step_cnt_nx;
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == DONE);
            err      <= err_nx;
            bus_req  <= bus_req_nx;
            bus_q    <= bus_nx;
            if (state_nx == DONE && !err_nx) begin
                key_data <= cap_data;
            end
        end
    end

    assign sser_n = bus_q.sser_n;
    assign ba13   = bus_q.ba13;
    assign ba12   = bus_q.ba12;
    assign ba     = bus_q.ba;
    assign br_w   = bus_q.br_w;

endmodule

// File: tb/tb_sser_key_sequencer.sv
// Directed bench for sser_key_sequencer: a key PAL model answers read strobes,
// and a scoreboard of expected done events is checked as each done appears.
module tb_sser_key_sequencer;

    localparam int NUM_BITS    = 16;
    localparam int UNLOCK_LEN  = 4;
    localparam int GNT_TIMEOUT = 255;
    localparam int LAT_OK      = 2 + 2 * (UNLOCK_LEN + NUM_BITS);
    localparam int LAT_TO      = GNT_TIMEOUT + 2;
    localparam int N_STROBES   = UNLOCK_LEN + NUM_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                err;
    logic [NUM_BITS-1:0] key_data;
    logic                bus_req;
    logic                bus_gnt;
    logic                sser_n;
    logic                ba13;
    logic                ba12;
    logic [3:0]          ba;
    logic                br_w;
    logic                sdrd;

    typedef struct {
        logic                err;
        logic [NUM_BITS-1:0] key;
        int                  due;
    } exp_t;

    exp_t       sb[$];
    int         strobe_cyc[$];
    logic [3:0] strobe_ba[$];
    logic [3:0] exp_unlock [UNLOCK_LEN] = '{4'h2, 4'h8, 4'hA, 4'h9};

    int                  n_cmp = 0;
    int                  n_fail = 0;
    int                  cyc = 0;
    int                  n_done = 0;
    int                  n_rd = 0;
    logic                done_seen = 1'b0;
    logic [NUM_BITS-1:0] mdl_word = '0;
    int                  mdl_bit = NUM_BITS - 1;
    logic                prev_strobe = 1'b0;
    logic [3:0]          prev_ba = 4'h0;

    sser_key_sequencer #(
        .NUM_BITS    (NUM_BITS),
        .UNLOCK_LEN  (UNLOCK_LEN),
        .GNT_TIMEOUT (GNT_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .key_data (key_data),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .sser_n   (sser_n),
        .ba13     (ba13),
        .ba12     (ba12),
        .ba       (ba),
        .br_w     (br_w),
        .sdrd     (sdrd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, err, bus_req}), 64'(0));
        check({tag, "_bus"}, 64'({sser_n, ba13, ba12, br_w, ba}), 64'(8'hC0));
        check({tag, "_key"}, 64'(key_data), 64'(0));
    endtask

    // One clock: sample outputs 1 time unit after the edge, run the PAL model
    // and pop the scoreboard on done.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!sser_n) begin
            strobe_cyc.push_back(cyc);
            strobe_ba.push_back(ba);
            check("strobe_addr", 64'({ba13, ba12, br_w}), 64'(3'b011));
            if (ba == 4'h2) mdl_bit = NUM_BITS - 1;
            if (ba == 4'h0) begin
                n_rd++;
                sdrd = mdl_word[mdl_bit];
                if (mdl_bit > 0) mdl_bit--;
            end else begin
                sdrd = 1'($urandom);
            end
        end else begin
            if (prev_strobe && bus_req)
                check("gap_hold", 64'({ba13, ba12, br_w, ba}), 64'({3'b011, prev_ba}));
            sdrd = 1'($urandom);
        end
        prev_strobe = !sser_n;
        prev_ba     = ba;
        if (done) begin
            done_seen = 1'b1;
            n_done++;
            check("done_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("done_err", 64'(err), 64'(e.err));
                check("done_key", 64'(key_data), 64'(e.key));
            end
        end else begin
            check("err_without_done", 64'(err), 64'(0));
        end
    endtask

    task automatic issue(input logic exp_err, input logic [NUM_BITS-1:0] exp_key, input int lat);
        exp_t e;
        e.err = exp_err;
        e.key = exp_key;
        e.due = cyc + lat;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done_seen), 64'(1));
    endtask

    initial begin
        int t0;
        int guard;
        int idle_cnt;
        int base;
        logic [3:0] exp_ba;

        rst     = 1'b1;
        start   = 1'b0;
        bus_gnt = 1'b1;
        sdrd    = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        repeat (5) tick();
        check_reset("idle_after_rst");

        // Full sequence with grant already held: strobe timing and key A5C3.
        mdl_word = 16'hA5C3;
        strobe_cyc.delete();
        strobe_ba.delete();
        t0 = cyc;
        issue(1'b0, 16'hA5C3, LAT_OK);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_bus_req", 64'(bus_req), 64'(1));
        check("t1_sser_in_req", 64'(sser_n), 64'(1));
        wait_done("t1_done", 60);
        check("t1_bus_req_at_done", 64'(bus_req), 64'(0));
        check("t1_busy_at_done", 64'(busy), 64'(1));
        check("t1_strobe_count", 64'(strobe_cyc.size()), 64'(N_STROBES));
        for (int i = 0; i < N_STROBES && i < strobe_cyc.size(); i++) begin
            exp_ba = (i < UNLOCK_LEN) ? exp_unlock[i] : 4'h0;
            check("t1_strobe_cyc", 64'(strobe_cyc[i]), 64'(t0 + 2 + 2 * i));
            check("t1_strobe_ba", 64'(strobe_ba[i]), 64'(exp_ba));
        end
        tick();
        check("t1_idle_after", 64'({busy, done, bus_req}), 64'(0));

        // Second key word.
        mdl_word = 16'h0001;
        issue(1'b0, 16'h0001, LAT_OK);
        wait_done("t2_done", 60);
        tick();

        // Grant never arrives: timeout, no strobes, key unchanged.
        bus_gnt = 1'b0;
        strobe_cyc.delete();
        issue(1'b1, 16'h0001, LAT_TO);
        check("t3_bus_req", 64'(bus_req), 64'(1));
        wait_done("t3_done", 300);
        check("t3_no_strobes", 64'(strobe_cyc.size()), 64'(0));
        check("t3_bus_req_at_done", 64'(bus_req), 64'(0));
        bus_gnt = 1'b1;
        tick();

        // Grant lost during the 5th read strobe.
        mdl_word = 16'h3C5A;
        n_rd = 0;
        issue(1'b1, 16'h0001, 2 + 2 * UNLOCK_LEN + 2 * 4 + 1);
        guard = 0;
        while (n_rd < 5 && guard < 40) begin
            tick();
            guard++;
        end
        check("t4_fifth_read", 64'(n_rd), 64'(5));
        bus_gnt = 1'b0;
        tick();
        check("t4_done", 64'(done), 64'(1));
        check("t4_sser_n", 64'(sser_n), 64'(1));
        check("t4_bus_req", 64'(bus_req), 64'(0));
        bus_gnt = 1'b1;
        tick();
        check("t4_after_done", 64'({busy, bus_req, sser_n}), 64'(3'b001));

        // Asynchronous reset while in an unlock gap.
        mdl_word = 16'h5AA5;
        issue(1'b0, 16'h5AA5, LAT_OK);
        tick();
        tick();
        check("t5_in_gap", 64'({busy, bus_req, sser_n}), 64'(3'b111));
        #2;
        rst = 1'b1;
        #1;
        check_reset("t5_async");
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        strobe_ba.delete();
        issue(1'b0, 16'h5AA5, LAT_OK);
        wait_done("t5_clean_done", 60);
        check("t5_strobe_count", 64'(strobe_ba.size()), 64'(N_STROBES));
        if (strobe_ba.size() != 0)
            check("t5_first_unlock", 64'(strobe_ba[0]), 64'(exp_unlock[0]));
        tick();

        // start held high: one done per accepted start, one idle cycle between.
        mdl_word = 16'hC33C;
        base     = n_done;
        idle_cnt = 0;
        t0       = cyc;
        sb.push_back('{err: 1'b0, key: 16'hC33C, due: t0 + LAT_OK});
        sb.push_back('{err: 1'b0, key: 16'hC33C, due: t0 + LAT_OK + 1 + LAT_OK});
        start = 1'b1;
        while (cyc < t0 + 60) begin
            tick();
            if (!busy) idle_cnt++;
        end
        start = 1'b0;
        guard = 0;
        while (n_done < base + 2 && guard < 60) begin
            tick();
            guard++;
        end
        check("t6_done_count", 64'(n_done - base), 64'(2));
        check("t6_idle_cycles", 64'(idle_cnt), 64'(1));
        check("t6_sb_drained", 64'(sb.size()), 64'(0));
        repeat (5) tick();
        check("t6_final_idle", 64'({busy, bus_req}), 64'(0));
        check("t6_final_key", 64'(key_data), 64'(16'hC33C));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
